// File: rtl/bounce_sprite_engine.sv
// Bouncing-sprite controller: moves a SPRITE_W x SPRITE_H window once per frame, bounces off screen edges,
// cycles colour on each bounce and colours ROM pixels; rgb is registered (1 cycle), no backpressure.
module bounce_sprite_engine #(
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int SPRITE_W = 128,
    parameter int SPRITE_H = 128,
    parameter int COORD_W  = 10,
    parameter int X_INIT   = 200,
    parameter int Y_INIT   = 200,
    parameter int SPEED_W  = 3
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic [COORD_W-1:0]          i_pix_x,
    input  logic [COORD_W-1:0]          i_pix_y,
    input  logic                        i_display_on,
    input  logic [SPEED_W-1:0]          i_speed_x,
    input  logic [SPEED_W-1:0]          i_speed_y,
    input  logic                        i_pause,
    output logic [$clog2(SPRITE_W)-1:0] o_rom_x,
    output logic [$clog2(SPRITE_H)-1:0] o_rom_y,
    input  logic                        i_rom_pixel,
    output logic [5:0]                  o_rgb,
    output logic                        o_frame_tick,
    output logic                        o_bounce,
    output logic                        o_corner_hit,
    output logic [15:0]                 o_bounce_count
);
    localparam int CW1 = COORD_W + 1;
    localparam logic [COORD_W:0]   XMAX = CW1'(H_RES - SPRITE_W);
    localparam logic [COORD_W:0]   YMAX = CW1'(V_RES - SPRITE_H);
    localparam logic [COORD_W-1:0] SW   = COORD_W'(SPRITE_W);
    localparam logic [COORD_W-1:0] SH   = COORD_W'(SPRITE_H);

    typedef struct packed {
        logic [COORD_W-1:0] pos;
        logic               dir_p;
        logic               hit;
    } axis_t;

    // One axis step at COORD_W+1 bits so neither the sum nor the compare can wrap.
    function automatic axis_t axis_step(input logic [COORD_W-1:0] pos, input logic dir_p,
                                        input logic [SPEED_W-1:0] spd, input logic [COORD_W:0] lim);
        logic [COORD_W:0] p_ext;
        logic [COORD_W:0] s_ext;
        logic [COORD_W:0] sum;
        logic [COORD_W:0] diff;
        axis_t r;
        p_ext   = {1'b0, pos};
        s_ext   = {{(CW1 - SPEED_W){1'b0}}, spd};
        sum     = p_ext + s_ext;
        diff    = p_ext - s_ext;
        r.pos   = pos;
        r.dir_p = dir_p;
        r.hit   = 1'b0;
        if (spd != '0) begin
            if (dir_p) begin
                if (sum >= lim) begin
                    r.pos   = lim[COORD_W-1:0];
                    r.dir_p = 1'b0;
                    r.hit   = 1'b1;
                end else begin
                    r.pos = sum[COORD_W-1:0];
                end
            end else begin
                if (p_ext <= s_ext) begin
                    r.pos   = '0;
                    r.dir_p = 1'b1;
                    r.hit   = 1'b1;
                end else begin
                    r.pos = diff[COORD_W-1:0];
                end
            end
        end
        return r;
    endfunction

    logic [COORD_W-1:0] r_cx, r_cy, r_prev_y;
    logic               r_dir_x, r_dir_y;
    logic [2:0]         r_colour;
    logic [5:0]         r_rgb;
    logic               r_frame_tick, r_bounce, r_corner;
    logic [15:0]        r_count;

    logic               w_frame_evt, w_any_hit, w_in_sprite;
    axis_t              w_ax, w_ay;
    logic [COORD_W-1:0] w_rel_x, w_rel_y;

    // Speeds are only looked at in the event cycle, so mid-frame changes have no effect.
    assign w_frame_evt = (i_pix_y == '0) && (r_prev_y != '0);
    assign w_ax        = axis_step(r_cx, r_dir_x, i_speed_x, XMAX);
    assign w_ay        = axis_step(r_cy, r_dir_y, i_speed_y, YMAX);
    assign w_any_hit   = w_ax.hit | w_ay.hit;

    assign w_rel_x     = i_pix_x - r_cx;
    assign w_rel_y     = i_pix_y - r_cy;
    assign w_in_sprite = (i_pix_x >= r_cx) && (w_rel_x < SW) &&
                         (i_pix_y >= r_cy) && (w_rel_y < SH);
    assign o_rom_x     = w_rel_x[$clog2(SPRITE_W)-1:0];
    assign o_rom_y     = w_rel_y[$clog2(SPRITE_H)-1:0];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cx         <= COORD_W'(X_INIT);
            r_cy         <= COORD_W'(Y_INIT);
            r_dir_x      <= 1'b1;
            r_dir_y      <= 1'b0;
            r_colour     <= 3'b111;
            r_prev_y     <= '0;
            r_rgb        <= '0;
            r_frame_tick <= 1'b0;
            r_bounce     <= 1'b0;
            r_corner     <= 1'b0;
            r_count      <= '0;
        end else begin
            r_prev_y     <= i_pix_y;
            r_frame_tick <= w_frame_evt;
            r_bounce     <= 1'b0;
            r_corner     <= 1'b0;
            if (w_frame_evt && !i_pause) begin
                r_cx     <= w_ax.pos;
                r_dir_x  <= w_ax.dir_p;
                r_cy     <= w_ay.pos;
                r_dir_y  <= w_ay.dir_p;
                r_bounce <= w_any_hit;
                r_corner <= w_ax.hit & w_ay.hit;
                if (w_any_hit) begin
                    r_count  <= r_count + 16'd1;
                    r_colour <= (r_colour == 3'd7) ? 3'd1 : r_colour + 3'd1;
                end
            end
            r_rgb <= (i_display_on && w_in_sprite && i_rom_pixel) ?
                     {{2{r_colour[2]}}, {2{r_colour[1]}}, {2{r_colour[0]}}} : 6'd0;
        end
    end

    assign o_rgb          = r_rgb;
    assign o_frame_tick   = r_frame_tick;
    assign o_bounce       = r_bounce;
    assign o_corner_hit   = r_corner;
    assign o_bounce_count = r_count;
endmodule
